// File: rtl/rgb_pwm_detect_pkg.sv
// Shared definitions for the RGB PWM pulse-width detector.
// The channel index constants are the same ones the PWM generator uses.
package rgb_pwm_detect_pkg;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } det_state_e;

  localparam int RED_INDEX   = 2;
  localparam int GREEN_INDEX = 1;
  localparam int BLUE_INDEX  = 0;

endpackage

// File: rtl/pwm_chan_detect.sv
// Single-channel pulse-width detector: synchronizer, edge detect, measuring FSM
// and latched high/low counts with a one-cycle report strobe.
module pwm_chan_detect
  import rgb_pwm_detect_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pwm_i,
  output logic [CNT_WIDTH-1:0] high_cnt_o,
  output logic [CNT_WIDTH-1:0] low_cnt_o,
  output logic                 duty_valid_o,
  output logic                 stuck_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  det_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_WIDTH-1:0] high_q, high_d, low_q, low_d;
  logic                 stuck_q, stuck_d, vld_q, vld_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACQ;
      hi_q    <= '0;
      lo_q    <= '0;
      high_q  <= '0;
      low_q   <= '0;
      stuck_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      high_q  <= high_d;
      low_q   <= low_d;
      stuck_q <= stuck_d;
      vld_q   <= vld_d;
    end
  end

  // Edges are tested before timeouts so an edge on the timeout cycle still counts.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    high_d  = high_q;
    low_d   = low_q;
    stuck_d = stuck_q;
    vld_d   = 1'b0;
    case (state_q)
      ST_ACQ: begin
        if (rise) begin
          hi_d    = CNT_ONE;
          lo_d    = '0;
          state_d = ST_HIGH;
        end else if (hi_q == CNT_MAX_M1) begin
          // Idle timer expires after MAX cycles; report the level it is stuck at.
          high_d  = s2_q ? CNT_MAX : '0;
          low_d   = s2_q ? '0 : CNT_MAX;
          stuck_d = 1'b1;
          vld_d   = 1'b1;
          hi_d    = '0;
        end else begin
          hi_d = sat_inc(hi_q);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          lo_d    = CNT_ONE;
          state_d = ST_LOW;
        end else if (hi_q == CNT_MAX) begin
          high_d  = CNT_MAX;
          low_d   = '0;
          stuck_d = 1'b1;
          vld_d   = 1'b1;
          hi_d    = '0;
          state_d = ST_ACQ;
        end else begin
          hi_d = sat_inc(hi_q);
        end
      end
      ST_LOW: begin
        if (rise) begin
          high_d  = hi_q;
          low_d   = lo_q;
          stuck_d = 1'b0;
          vld_d   = 1'b1;
          hi_d    = CNT_ONE;
          lo_d    = '0;
          state_d = ST_HIGH;
        end else if (lo_q == CNT_MAX) begin
          high_d  = '0;
          low_d   = CNT_MAX;
          stuck_d = 1'b1;
          vld_d   = 1'b1;
          hi_d    = '0;
          state_d = ST_ACQ;
        end else begin
          lo_d = sat_inc(lo_q);
        end
      end
      default: begin
        state_d = ST_ACQ;
        hi_d    = '0;
        lo_d    = '0;
      end
    endcase
  end

  assign high_cnt_o   = high_q;
  assign low_cnt_o    = low_q;
  assign duty_valid_o = vld_q;
  assign stuck_o      = stuck_q;

endmodule

// File: rtl/rgb_pwm_detect.sv
// Multi-channel PWM pulse-width detector: one independent detector per channel,
// outputs packed with channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].
module rgb_pwm_detect
  import rgb_pwm_detect_pkg::*;
#(
  parameter int PWM_CH_COUNT = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [PWM_CH_COUNT-1:0]           PWM_IN,
  output logic [PWM_CH_COUNT*CNT_WIDTH-1:0] HIGH_CNT,
  output logic [PWM_CH_COUNT*CNT_WIDTH-1:0] LOW_CNT,
  output logic [PWM_CH_COUNT-1:0]           DUTY_VALID,
  output logic [PWM_CH_COUNT-1:0]           STUCK
);

  for (genvar g = 0; g < PWM_CH_COUNT; g++) begin : g_chan
    pwm_chan_detect #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_det (
      .clk_i       (CLK),
      .rst_ni      (RESET),
      .pwm_i       (PWM_IN[g]),
      .high_cnt_o  (HIGH_CNT[g*CNT_WIDTH +: CNT_WIDTH]),
      .low_cnt_o   (LOW_CNT[g*CNT_WIDTH +: CNT_WIDTH]),
      .duty_valid_o(DUTY_VALID[g]),
      .stuck_o     (STUCK[g])
    );
  end

endmodule
